// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the instruction-fetch path
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8002_0000;
    localparam int INSN_W = 32;

    typedef enum logic {RUN, FLUSH} fetch_state_t;

    typedef struct packed {
        logic [INSN_W-1:0] instruction;
        logic [31:0]       pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush and combinational head (zero when empty)
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] rd, wr;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign rdata   = empty ? '0 : mem[rd];

    // Pointer and occupancy tracking; flush empties the queue in one cycle
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= inc(wr);
            if (do_pop) rd <= inc(rd);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clock) begin
        if (do_push) mem[wr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with in-order tag tracking and redirect flush
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [INSN_W-1:0] instruction,
    output logic [31:0]       pc
);
    localparam int CW = $clog2(DEPTH + 2);

    fetch_state_t state;
    fetch_entry_t head;
    logic [31:0] fetch_pc, tag_head;
    logic [CW-1:0] discard, disc_next, tag_cnt, buf_cnt;
    logic tag_empty, buf_empty, pop, grant, rsp, credit;

    assign pop         = insn_valid && insn_ready;
    assign credit      = tag_cnt + buf_cnt - CW'(pop) < CW'(DEPTH);
    assign imem_req    = !reset && !redirect && state == RUN && credit;
    assign grant       = imem_req && imem_gnt;
    assign rsp         = imem_rvalid && state == RUN && !tag_empty;
    assign imem_addr   = fetch_pc;
    assign insn_valid  = !buf_empty;
    assign instruction = head.instruction;
    assign pc          = head.pc;

    // Discard count: captured from in-flight requests on a RUN redirect, then drained per response
    always_comb
        disc_next = redirect && state == RUN ? tag_cnt - CW'(rsp) + CW'(grant)
                                             : discard - CW'(imem_rvalid && discard != '0);

    // Fetch PC and RUN/FLUSH control; redirect overrides every same-cycle event
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            discard  <= '0;
        end else begin
            discard <= disc_next;
            state   <= (redirect || state == FLUSH) && disc_next != '0 ? FLUSH : RUN;
            if (redirect) fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (grant) fetch_pc <= fetch_pc + 32'd4;
        end
    end

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH), .CW(CW)) u_tags (
        .clock (clock),
        .reset (reset),
        .flush (redirect),
        .push  (grant),
        .wdata (fetch_pc),
        .pop   (rsp),
        .rdata (tag_head),
        .count (tag_cnt),
        .empty (tag_empty)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH), .CW(CW)) u_buf (
        .clock (clock),
        .reset (reset),
        .flush (redirect),
        .push  (rsp && !redirect),
        .wdata ({imem_rdata, tag_head}),
        .pop   (pop),
        .rdata (head),
        .count (buf_cnt),
        .empty (buf_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-configurable memory model
module tb_fetch_unit;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clock = 0, reset = 1;
    logic imem_req, imem_gnt = 1, imem_rvalid = 0, redirect = 0, insn_valid, insn_ready = 0;
    logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, instruction, pc;
    logic w_req, w_rvalid = 0, w_valid, w_g = 0;
    logic [31:0] w_addr, w_rdata = 0, w_insn, w_pc, w_ga = 0, e_pc, e_w;
    int n_cmp = 0, n_bad = 0, cyc = 0, lat = 1, grants = 0, consumed = 0, first_cyc = 0, last_cyc = 0;
    logic [31:0] exp_q[$], w_q[$];
    mreq_t mq[$];

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .insn_valid(insn_valid), .insn_ready(insn_ready),
        .instruction(instruction), .pc(pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clock(clock), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect(1'b0), .redirect_pc(32'h0),
        .insn_valid(w_valid), .insn_ready(1'b1),
        .instruction(w_insn), .pc(w_pc)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h2402_0005 + (a - 32'h8002_0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hold_reset();
        reset = 1;
        redirect = 0;
        insn_ready = 0;
        imem_gnt = 1;
        exp_q.delete();
        consumed = 0;
        repeat (3) tick();
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic drain(input int budget);
        wait_empty(budget);
        insn_ready = 0;
    endtask

    // Cycle counter used for latency and throughput bookkeeping
    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: in-order responses 'lat' cycles after each grant
    always @(negedge clock) begin
        if (reset) begin
            mq.delete();
            imem_rvalid = 0;
            grants = 0;
        end else begin
            if (imem_rvalid) void'(mq.pop_front());
            if (imem_req && imem_gnt) begin
                mq.push_back('{imem_addr, cyc + lat});
                grants++;
            end
            imem_rvalid = mq.size() != 0 && mq[0].due <= cyc;
        end
        imem_rdata = mq.size() != 0 ? word(mq[0].addr) : 32'h0;
    end

    // Scoreboard: every consumed instruction must match the next expected pc
    always @(negedge clock) begin
        if (!reset && !redirect && insn_valid && insn_ready) begin
            if (exp_q.size() == 0) check("extra_out", 32'(exp_q.size()), 32'd1);
            else begin
                e_pc = exp_q.pop_front();
                check("pc", pc, e_pc);
                check("insn", instruction, word(e_pc));
                if (consumed == 0) first_cyc = cyc;
                last_cyc = cyc;
                consumed++;
            end
        end
    end

    // Wrap instance: 1-cycle memory, always ready, checked against its own queue
    always @(negedge clock) begin
        if (!reset && w_valid && w_q.size() != 0) begin
            e_w = w_q.pop_front();
            check("wrap_pc", w_pc, e_w);
            check("wrap_insn", w_insn, word(e_w));
        end
        w_rvalid = w_g && !reset;
        w_rdata = word(w_ga);
        w_g = w_req;
        w_ga = w_addr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        w_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

        // Reset values and streaming from reset release
        hold_reset();
        @(negedge clock);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h8002_0000);
        check("rst_valid", 32'(insn_valid), 32'd0);
        check("rst_insn", instruction, 32'd0);
        check("rst_pc", pc, 32'd0);
        tick();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h8002_0000 + 32'(4 * i));
        lat = 1;
        insn_ready = 1;
        reset = 0;
        @(negedge clock);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h8002_0000);
        drain(40);
        check("rate", 32'(last_cyc - first_cyc), 32'd7);

        // Decoder stall: two buffered, requests held off, outputs stable
        hold_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h8002_0000 + 32'(4 * i));
        reset = 0;
        repeat (6) tick();
        check("stall_grants", 32'(grants), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_req", 32'(imem_req), 32'd0);
            check("stall_valid", 32'(insn_valid), 32'd1);
            check("stall_pc", pc, 32'h8002_0000);
        end
        tick();
        insn_ready = 1;
        drain(40);

        // Redirect with two requests in flight at 3-cycle latency
        hold_reset();
        lat = 3;
        insn_ready = 1;
        reset = 0;
        for (int i = 0; i < 20 && grants < 2; i++) tick();
        check("pre_redir_grants", 32'(grants), 32'd2);
        redirect = 1;
        redirect_pc = 32'h8002_0103;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h8002_0100 + 32'(4 * i));
        @(negedge clock);
        check("redir_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 0;
        @(negedge clock);
        check("flush_req", 32'(imem_req), 32'd0);
        drain(60);

        // Redirect coinciding with a pop opportunity while streaming
        hold_reset();
        lat = 1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h8002_0000 + 32'(4 * i));
        insn_ready = 1;
        reset = 0;
        wait_empty(40);
        redirect = 1;
        redirect_pc = 32'h8002_0200;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h8002_0200 + 32'(4 * i));
        @(negedge clock);
        check("coinc_valid", 32'(insn_valid), 32'd1);
        check("coinc_pc", pc, 32'h8002_000C);
        check("coinc_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 0;
        drain(40);

        // Grant withheld for 4 cycles
        hold_reset();
        imem_gnt = 0;
        insn_ready = 1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h8002_0000 + 32'(4 * i));
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("nognt_req", 32'(imem_req), 32'd1);
            check("nognt_addr", imem_addr, 32'h8002_0000);
            check("nognt_valid", 32'(insn_valid), 32'd0);
        end
        tick();
        imem_gnt = 1;
        drain(40);

        check("wrap_done", 32'(w_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
